alu_exec_multicycle: RTL
========================

Name: alu_exec_multicycle

Overview:
- Execute-stage ALU that sits directly downstream of the ALU decoder.
- Consumes the 3-bit ALU_Control code plus two operands and produces a registered result and a zero flag.
- Single-cycle ops: ADD/SUB/AND/COMPARE. LEFT_SHIFT is iterative, one bit per cycle.
- A start/ready/done handshake lets the control FSM stall on long shifts.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width (log2 WIDTH); shift amount is B[SHAMT_W-1:0]

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when ready=1
ALU_Control  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 LEFT_SHIFT, 100 COMPARE
A  input  WIDTH  operand A
B  input  WIDTH  operand B / shift amount
ready  output  1  high in IDLE only (combinational from state)
busy  output  1  high in SHIFT state
done  output  1  one-cycle pulse; result/zero valid
result  output  WIDTH  registered result, held until next accepted start
zero  output  1  registered (result == 0), updated with result

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset (async, any state): state=IDLE, result=0, zero=0, done=0, busy=0, shift counter=0. ready=1 as soon as reset is asserted.
- States: IDLE, SHIFT, DONE.
- Accept: rising edge with state=IDLE and start=1. A, B and ALU_Control are sampled only at that edge; later input changes are ignored.
- start while state != IDLE is ignored (no queueing).
- Non-shift ops at accept edge: result and zero are written, state goes to DONE. done is high for the next cycle (latency 1).
- ADD: A+B mod 2^WIDTH; carry discarded.
- SUB: A-B mod 2^WIDTH.
- AND: A&B.
- COMPARE: signed A<B gives 1, else 0; zero-extended to WIDTH.
- Codes 101/110/111: treated as ADD (matches decoder default).
- LEFT_SHIFT at accept edge: result=A, counter=B[SHAMT_W-1:0]. Upper bits of B are ignored.
  - n==0: state goes to DONE (latency 1, result=A).
  - n>0: state goes to SHIFT. Each SHIFT edge does result<<=1 (zero fill) and counter-=1.
  - When the counter is 1 at an edge, that edge performs the final shift and moves to DONE.
  - Total latency n+1 cycles from the accept edge; busy is high for n cycles.
- zero is recomputed from the new result on every edge that writes result.
- DONE: done=1 for exactly one cycle, then IDLE. ready=0 in DONE, so minimum issue interval is 2 cycles.
- result/zero hold their values in IDLE until the next accept.
- Reset during SHIFT or DONE aborts the operation. No done pulse is produced for the aborted op.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: LEFT_SHIFT is a one-cycle barrel shift, A << B[SHAMT_W-1:0], computed at the accept edge and going straight to DONE. The SHIFT state is unused and busy stays 0. Latency is 1 for every op.
- Undefined: iterative shifter as specified above.

Test Plan:
- Reset mid-SHIFT: issue LEFT_SHIFT A=1, B=31; assert rst on cycle 5 -> immediate result=0, zero=0, ready=1, no done pulse. Next ADD 2+3 -> result=5 after 1 cycle.
- ALU ops: ADD 0xFFFFFFFF+1 -> result=0, zero=1, done one cycle after accept. SUB 10-3 -> 7, zero=0. AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000.
- COMPARE: A=0xFFFFFFFF (-1), B=1 -> result=1. A=5, B=-2 -> result=0, zero=1. Code 111 with 4+4 -> result=8.
- LEFT_SHIFT A=0x3, B=0x00000104 (n=4) -> busy high 4 cycles, done at cycle 5, result=0x30. With ALU_FAST_SHIFT_EN: done at cycle 1, result=0x30.
- Shift boundaries: n=0 -> result=A, done at cycle 1. A=0x80000001, n=31 -> result=0x80000000. A=0x80000000, n=1 -> result=0, zero=1.
- Handshake: start held high continuously with changing ops -> accepts only in IDLE (every 2 cycles for ALU ops). A start pulse during SHIFT is dropped. Inputs changed after accept do not affect the result.

Source files
------------

// File: rtl/alu_exec_multicycle.sv
// alu_exec_multicycle: execute-stage ALU with start/ready/done handshake and iterative left shift
// Ports: clk, rst (async active-high); start, ALU_Control[2:0], A, B in;
//        ready (IDLE), busy (SHIFT), done (one-cycle pulse), result, zero out.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shift.
module alu_exec_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] result_n, alu;
  logic wr;
  assign ready = state == IDLE;
  assign busy  = state == SHIFT;
  assign done  = state == DONE;
  // Unused codes fall through to ADD, matching the decoder default.
  always_comb
    alu = ALU_Control == 3'b001 ? A - B :
          ALU_Control == 3'b010 ? A & B :
          ALU_Control == 3'b100 ? {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)} :
          A + B;
  always_comb begin
    state_n  = state;
    result_n = result;
    cnt_n    = cnt;
    wr       = 1'b0;
    case (state)
      IDLE: if (start) begin
        wr = 1'b1;
        if (ALU_Control == 3'b011) begin
`ifdef ALU_FAST_SHIFT_EN
          result_n = A << B[SHAMT_W-1:0];
          state_n  = DONE;
`else
          result_n = A;
          cnt_n    = B[SHAMT_W-1:0];
          state_n  = cnt_n == '0 ? DONE : SHIFT;
`endif
        end else begin
          result_n = alu;
          state_n  = DONE;
        end
      end
      SHIFT: begin
        wr       = 1'b1;
        result_n = {result[WIDTH-2:0], 1'b0};
        cnt_n    = cnt - 1'b1;
        state_n  = cnt == SHAMT_W'(1) ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (wr) begin
        result <= result_n;
        zero   <= result_n == '0;
      end
    end
endmodule
